// File: rtl/alu_control_seq_pkg.sv
// Shared constants for the ALU control sequencer: opcode values, ALU-op codes
// and the sequencing FSM state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] OPC_J    = 4'b1011;
    localparam logic [3:0] OPC_LW   = 4'b1000;
    localparam logic [3:0] OPC_SW   = 4'b1001;
    localparam logic [3:0] OPC_BEQ  = 4'b1010;
    localparam logic [3:0] OPC_MUL  = 4'b1100;
    localparam logic [3:0] OPC_DIV  = 4'b1101;
    localparam logic [3:0] OPC_RSV0 = 4'b1110;
    localparam logic [3:0] OPC_RSV1 = 4'b1111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/alu_control_seq_if.sv
// Bundle between the control FSM / ALU (master) and the ALU control sequencer (slave).
interface alu_control_seq_if #(
    parameter int OPC_W   = 4,
    parameter int STATE_W = 4
) ();

    logic [1:0]         OpAlu;
    logic [OPC_W-1:0]   Opcode;
    logic [STATE_W-1:0] state;
    logic               op_valid;
    logic               flush;
    logic               alu_done;

    logic [OPC_W-1:0]   alu_op;
    logic               alu_start;
    logic               busy;
    logic               op_done;
    logic               illegal;
    logic               timeout_err;

    modport master (
        output OpAlu, Opcode, state, op_valid, flush, alu_done,
        input  alu_op, alu_start, busy, op_done, illegal, timeout_err
    );

    modport slave (
        input  OpAlu, Opcode, state, op_valid, flush, alu_done,
        output alu_op, alu_start, busy, op_done, illegal, timeout_err
    );

endinterface

// File: rtl/alu_control_seq_decode.sv
// Combinational decode of (OpAlu, Opcode, control state) into an ALU op,
// flagging multi-cycle ops and reserved opcodes.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int                 OPC_W      = 4,
    parameter int                 STATE_W    = 4,
    parameter logic [STATE_W-1:0] ST_BR_ADDR = 4'b0001,
    parameter logic [STATE_W-1:0] ST_BR_CMP  = 4'b1000
) (
    input  logic [1:0]         i_opalu,
    input  logic [OPC_W-1:0]   i_opcode,
    input  logic [STATE_W-1:0] i_state,
    output logic [OPC_W-1:0]   o_op,
    output logic               o_is_multi,
    output logic               o_is_illegal
);

    localparam logic [OPC_W-1:0] C_J    = OPC_W'(OPC_J);
    localparam logic [OPC_W-1:0] C_LW   = OPC_W'(OPC_LW);
    localparam logic [OPC_W-1:0] C_SW   = OPC_W'(OPC_SW);
    localparam logic [OPC_W-1:0] C_BEQ  = OPC_W'(OPC_BEQ);
    localparam logic [OPC_W-1:0] C_MUL  = OPC_W'(OPC_MUL);
    localparam logic [OPC_W-1:0] C_DIV  = OPC_W'(OPC_DIV);
    localparam logic [OPC_W-1:0] C_RSV0 = OPC_W'(OPC_RSV0);
    localparam logic [OPC_W-1:0] C_RSV1 = OPC_W'(OPC_RSV1);
    localparam logic [OPC_W-1:0] C_ADD  = OPC_W'(ALU_ADD);
    localparam logic [OPC_W-1:0] C_SUB  = OPC_W'(ALU_SUB);

    // First match wins; a BEQ outside its two branch states falls through to the generic rules.
    always_comb begin
        o_op         = i_opcode;
        o_is_multi   = 1'b0;
        o_is_illegal = 1'b0;
        if (i_opcode == C_J || i_opcode == C_LW || i_opcode == C_SW) begin
            o_op = C_ADD;
        end else if (i_opcode == C_BEQ && i_state == ST_BR_ADDR) begin
            o_op = C_ADD;
        end else if (i_opcode == C_BEQ && i_state == ST_BR_CMP) begin
            o_op = C_SUB;
        end else if (i_opalu == 2'b00) begin
            o_op = C_ADD;
        end else if (i_opcode == C_RSV0 || i_opcode == C_RSV1) begin
            o_op         = C_ADD;
            o_is_illegal = 1'b1;
        end else begin
            o_op       = i_opcode;
            o_is_multi = (i_opcode == C_MUL) || (i_opcode == C_DIV);
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control: decodes the ALU op and sequences MUL/DIV through a
// start/done handshake with a timeout watchdog.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int                 OPC_W      = 4,
    parameter int                 STATE_W    = 4,
    parameter logic [STATE_W-1:0] ST_BR_ADDR = 4'b0001,
    parameter logic [STATE_W-1:0] ST_BR_CMP  = 4'b1000,
    parameter int                 TIMEOUT    = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    alu_control_seq_if.slave  bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    ctrl_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [OPC_W-1:0]   r_alu_op;
    logic               r_alu_start;
    logic               r_busy;
    logic               r_op_done;
    logic               r_illegal;
    logic               r_timeout_err;

    logic [OPC_W-1:0]   w_op;
    logic               w_is_multi;
    logic               w_is_illegal;

    alu_op_decode #(
        .OPC_W      (OPC_W),
        .STATE_W    (STATE_W),
        .ST_BR_ADDR (ST_BR_ADDR),
        .ST_BR_CMP  (ST_BR_CMP)
    ) u_decode (
        .i_opalu      (bus.OpAlu),
        .i_opcode     (bus.Opcode),
        .i_state      (bus.state),
        .o_op         (w_op),
        .o_is_multi   (w_is_multi),
        .o_is_illegal (w_is_illegal)
    );

    // Pulse outputs default low each cycle; flush outranks done, done outranks the timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_alu_op      <= '0;
            r_alu_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_op_done     <= 1'b0;
            r_illegal     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_op_done   <= 1'b0;
            r_illegal   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        r_alu_op  <= w_op;
                        r_illegal <= w_is_illegal;
                        if (w_is_multi) begin
                            r_alu_start <= 1'b1;
                            r_busy      <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (bus.flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (bus.alu_done) begin
                        r_busy    <= 1'b0;
                        r_op_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_op      = r_alu_op;
    assign bus.alu_start   = r_alu_start;
    assign bus.busy        = r_busy;
    assign bus.op_done     = r_op_done;
    assign bus.illegal     = r_illegal;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: each stimulus cycle queues its expected
// outputs, and a monitor pops and compares one entry per clock.
module tb_alu_control_seq;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    alu_control_seq_if #(.OPC_W(4), .STATE_W(4)) bus ();

    alu_control_seq #(
        .OPC_W      (4),
        .STATE_W    (4),
        .ST_BR_ADDR (4'b0001),
        .ST_BR_CMP  (4'b1000),
        .TIMEOUT    (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Flag vector order: {alu_start, busy, op_done, illegal, timeout_err}
    localparam logic [4:0] F_NONE  = 5'b00000;
    localparam logic [4:0] F_START = 5'b11000;
    localparam logic [4:0] F_BUSY  = 5'b01000;
    localparam logic [4:0] F_DONE  = 5'b00100;
    localparam logic [4:0] F_ILL   = 5'b00010;
    localparam logic [4:0] F_TERR  = 5'b00001;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [4:0] flags;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic checkOutput(input string name, input logic [3:0] expOp, input logic [4:0] expFlags);
        logic [4:0] act;
        act = {bus.alu_start, bus.busy, bus.op_done, bus.illegal, bus.timeout_err};
        checks++;
        if (bus.alu_op !== expOp || act !== expFlags) begin
            failures++;
            $display("[TB] FAIL %s: got alu_op=%b flags(start,busy,done,ill,terr)=%b, expected alu_op=%b flags=%b",
                     name, bus.alu_op, act, expOp, expFlags);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [1:0] opAlu, input logic [3:0] opcode,
                                 input logic [3:0] st, input logic valid, input logic fl, input logic done,
                                 input logic [3:0] expOp, input logic [4:0] expFlags);
        exp_t e;
        @(negedge clock);
        bus.OpAlu    = opAlu;
        bus.Opcode   = opcode;
        bus.state    = st;
        bus.op_valid = valid;
        bus.flush    = fl;
        bus.alu_done = done;
        e.name  = name;
        e.op    = expOp;
        e.flags = expFlags;
        expQ.push_back(e);
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, e.op, e.flags);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.OpAlu    = 2'b00;
        bus.Opcode   = 4'b0000;
        bus.state    = 4'b0000;
        bus.op_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.alu_done = 1'b0;
        reset_n      = 1'b0;

        repeat (2) @(negedge clock);
        bus.OpAlu    = 2'b10;
        bus.Opcode   = 4'b1100;
        bus.op_valid = 1'b1;
        @(negedge clock);
        checkOutput("reset_state", 4'b0000, F_NONE);
        bus.op_valid = 1'b0;
        reset_n      = 1'b1;

        // Decode paths
        applyStimulus("rtype_5",        2'b10, 4'b0101, 4'b0000, 1, 0, 0, 4'b0101, F_NONE);
        applyStimulus("lw_add",         2'b01, 4'b1000, 4'b0000, 1, 0, 0, 4'b0000, F_NONE);
        applyStimulus("rtype_3",        2'b10, 4'b0011, 4'b0000, 1, 0, 0, 4'b0011, F_NONE);
        applyStimulus("beq_addr_add",   2'b01, 4'b1010, 4'b0001, 1, 0, 0, 4'b0000, F_NONE);
        applyStimulus("beq_cmp_sub",    2'b01, 4'b1010, 4'b1000, 1, 0, 0, 4'b0001, F_NONE);
        applyStimulus("beq_other_st",   2'b01, 4'b1010, 4'b0100, 1, 0, 0, 4'b1010, F_NONE);
        applyStimulus("beq_opalu00",    2'b00, 4'b1010, 4'b0100, 1, 0, 0, 4'b0000, F_NONE);
        applyStimulus("rtype_7",        2'b10, 4'b0111, 4'b0000, 1, 0, 0, 4'b0111, F_NONE);
        applyStimulus("hold_no_valid",  2'b10, 4'b0010, 4'b0000, 0, 0, 0, 4'b0111, F_NONE);
        applyStimulus("sw_add",         2'b10, 4'b1001, 4'b0000, 1, 0, 0, 4'b0000, F_NONE);
        applyStimulus("rtype_4",        2'b10, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, F_NONE);
        applyStimulus("j_add",          2'b10, 4'b1011, 4'b0000, 1, 0, 0, 4'b0000, F_NONE);
        applyStimulus("rtype_6",        2'b10, 4'b0110, 4'b0000, 1, 0, 0, 4'b0110, F_NONE);
        applyStimulus("pcinc_rsv_op",   2'b00, 4'b1110, 4'b0000, 1, 0, 0, 4'b0000, F_NONE);

        // MUL with alu_done five cycles after start; op_valid in WAIT is ignored
        applyStimulus("mul_start",      2'b10, 4'b1100, 4'b0000, 1, 0, 0, 4'b1100, F_START);
        applyStimulus("mul_wait1",      2'b10, 4'b1100, 4'b0000, 0, 0, 0, 4'b1100, F_BUSY);
        applyStimulus("mul_wait_valid", 2'b10, 4'b0101, 4'b0000, 1, 0, 0, 4'b1100, F_BUSY);
        applyStimulus("mul_wait3",      2'b10, 4'b0101, 4'b0000, 0, 0, 0, 4'b1100, F_BUSY);
        applyStimulus("mul_wait4",      2'b10, 4'b0101, 4'b0000, 0, 0, 0, 4'b1100, F_BUSY);
        applyStimulus("mul_done",       2'b10, 4'b0101, 4'b0000, 0, 0, 1, 4'b1100, F_DONE);
        applyStimulus("idle_done_ign",  2'b10, 4'b0101, 4'b0000, 0, 0, 1, 4'b1100, F_NONE);

        // Flush beats a same-cycle alu_done; flush in IDLE does nothing
        applyStimulus("mul2_start",     2'b10, 4'b1100, 4'b0000, 1, 0, 0, 4'b1100, F_START);
        applyStimulus("flush_and_done", 2'b10, 4'b1100, 4'b0000, 0, 1, 1, 4'b1100, F_NONE);
        applyStimulus("idle_flush",     2'b10, 4'b1100, 4'b0000, 0, 1, 0, 4'b1100, F_NONE);
        applyStimulus("after_flush",    2'b10, 4'b0010, 4'b0000, 1, 0, 0, 4'b0010, F_NONE);

        // DIV whose alu_done lands exactly on the timeout cycle counts as success
        applyStimulus("div_start",      2'b10, 4'b1101, 4'b0000, 1, 0, 0, 4'b1101, F_START);
        for (int i = 0; i < 7; i++)
            applyStimulus("div_wait",   2'b10, 4'b1101, 4'b0000, 0, 0, 0, 4'b1101, F_BUSY);
        applyStimulus("div_done_limit", 2'b10, 4'b1101, 4'b0000, 0, 0, 1, 4'b1101, F_DONE);

        // DIV with no alu_done: busy for 8 cycles, then sticky timeout_err
        applyStimulus("div2_start",     2'b10, 4'b1101, 4'b0000, 1, 0, 0, 4'b1101, F_START);
        for (int i = 0; i < 7; i++)
            applyStimulus("div2_wait",  2'b10, 4'b1101, 4'b0000, 0, 0, 0, 4'b1101, F_BUSY);
        applyStimulus("div2_timeout",   2'b10, 4'b1101, 4'b0000, 0, 0, 0, 4'b1101, F_TERR);
        applyStimulus("terr_sticky",    2'b10, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, F_TERR);

        // Reserved opcodes
        applyStimulus("rsv_1110",       2'b10, 4'b1110, 4'b0000, 1, 0, 0, 4'b0000, F_ILL | F_TERR);
        applyStimulus("ill_one_pulse",  2'b10, 4'b1110, 4'b0000, 0, 0, 0, 4'b0000, F_TERR);
        applyStimulus("rsv_1111",       2'b10, 4'b1111, 4'b0000, 1, 0, 0, 4'b0000, F_ILL | F_TERR);

        // Asynchronous reset in the middle of a WAIT
        applyStimulus("mul3_start",     2'b10, 4'b1100, 4'b0000, 1, 0, 0, 4'b1100, F_START | F_TERR);
        applyStimulus("mul3_wait",      2'b10, 4'b1100, 4'b0000, 0, 0, 0, 4'b1100, F_BUSY | F_TERR);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, F_NONE);
        @(negedge clock);
        checkOutput("reset_held", 4'b0000, F_NONE);
        reset_n = 1'b1;
        applyStimulus("post_reset_op",  2'b10, 4'b0101, 4'b0000, 1, 0, 0, 4'b0101, F_NONE);
        applyStimulus("post_reset_idle",2'b10, 4'b0101, 4'b0000, 0, 0, 0, 4'b0101, F_NONE);

        repeat (3) @(negedge clock);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
